// File: rtl/cpu_types_pkg.sv
// Shared CPU types: immediate selector, RV32 major opcodes and the decode
// pipeline slot carried from IDU to EXU.
package cpu_types_pkg;

  // Immediate format selector consumed by ImmGen; IMM_I encodes as zero so
  // an all-zero slot is the natural reset value.
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } immsel_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Widest PC any instantiation may carry; narrower PCs are zero-extended.
  localparam int unsigned DEC_PC_MAX_W = 64;

  typedef struct packed {
    logic [31:0]             inst;
    logic [DEC_PC_MAX_W-1:0] pc;
    logic [31:0]             imm;
    immsel_e                 immsel;
    logic                    illegal;
  } dec_slot_t;

  localparam dec_slot_t DEC_SLOT_RST = '0;

endpackage

// File: rtl/ImmGen.sv
// Combinational RV32 immediate generator: sign-extends / reassembles the
// immediate field of an instruction according to the selected format.
module ImmGen
  import cpu_types_pkg::*;
(
  input  logic [31:0] inst,
  input  immsel_e     immsel,
  output logic [31:0] imm
);

  // Format mux over the five RV32 immediate layouts.
  always_comb begin
    imm = '0;
    unique case (immsel)
      IMM_I: imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U: imm = {inst[31:12], 12'b0};
      IMM_J: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/idu_imm_ctrl.sv
// Decode-stage controller: classifies the opcode, generates the immediate
// through ImmGen and holds the result in a registered slot toward the EXU
// with valid/ready flow control and flush.
// Optional feature macro: IDU_SKID_EN (adds a skid entry and registers
// in_ready); undefined gives a single slot with combinational in_ready.
module idu_imm_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_imm,
  output immsel_e         out_immsel,
  output logic            out_illegal
);

  immsel_e     dec_sel;
  logic        dec_illegal;
  logic        dec_zero_imm;
  logic [31:0] gen_imm;
  dec_slot_t   new_slot;

  dec_slot_t   slot_q;
  logic        valid_q;
  logic        accept;

  // Opcode classification into immediate selector and illegal flag.
  always_comb begin
    dec_sel      = IMM_I;
    dec_illegal  = 1'b0;
    dec_zero_imm = 1'b0;
    if (in_inst[1:0] != 2'b11) begin
      dec_illegal  = 1'b1;
      dec_zero_imm = 1'b1;
    end else begin
      unique case (in_inst[6:0])
        OPC_LUI, OPC_AUIPC:                      dec_sel = IMM_U;
        OPC_JAL:                                 dec_sel = IMM_J;
        OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_SYSTEM: dec_sel = IMM_I;
        OPC_STORE:                               dec_sel = IMM_S;
        OPC_BRANCH:                              dec_sel = IMM_B;
        OPC_OP:                                  dec_zero_imm = 1'b1;
        default: begin
          dec_illegal  = 1'b1;
          dec_zero_imm = 1'b1;
        end
      endcase
    end
  end

  ImmGen u_immgen (
    .inst   (in_inst),
    .immsel (dec_sel),
    .imm    (gen_imm)
  );

  // Assemble the slot image that an accepted beat would load.
  always_comb begin
    new_slot                = DEC_SLOT_RST;
    new_slot.inst           = in_inst;
    new_slot.pc[PC_W-1:0]   = in_pc;
    new_slot.imm            = dec_zero_imm ? '0 : gen_imm;
    new_slot.immsel         = dec_sel;
    new_slot.illegal        = dec_illegal;
  end

  assign accept = in_valid && in_ready && !flush;

`ifdef IDU_SKID_EN
  dec_slot_t skid_q;
  logic      skid_valid_q;

  // in_ready comes straight from a flop, cutting the out_ready -> in_ready path.
  assign in_ready = !skid_valid_q;

  // Main slot plus skid entry; a beat arriving while the main slot is
  // stalled parks in the skid entry and is promoted when the main slot drains.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
      slot_q       <= DEC_SLOT_RST;
      skid_q       <= DEC_SLOT_RST;
    end else if (flush) begin
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!valid_q) begin
      if (accept) begin
        slot_q  <= new_slot;
        valid_q <= 1'b1;
      end
    end else if (out_ready) begin
      if (skid_valid_q) begin
        slot_q       <= skid_q;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        slot_q <= new_slot;
      end else begin
        valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= new_slot;
      skid_valid_q <= 1'b1;
    end
  end
`else
  // Single slot: accept whenever the slot is empty or being consumed now.
  assign in_ready = !valid_q || out_ready;

  // Slot load on accept, clear on consume, kill on flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      slot_q  <= DEC_SLOT_RST;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      slot_q  <= new_slot;
      valid_q <= 1'b1;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end
`endif

  assign out_valid   = valid_q;
  assign out_inst    = slot_q.inst;
  assign out_pc      = slot_q.pc[PC_W-1:0];
  assign out_imm     = slot_q.imm;
  assign out_immsel  = slot_q.immsel;
  assign out_illegal = slot_q.illegal;

endmodule

// File: doc/idu_imm_ctrl.md
# idu_imm_ctrl

Decode-stage controller that accepts fetched instructions from the IFU over a valid/ready handshake and classifies the opcode into an `immsel_e` selector. It drives the existing `ImmGen` combinational generator with that selector and registers the instruction, PC, immediate, selector and an illegal flag into a single pipeline slot toward the EXU. It sits between the IFU and EXU in the NPC core. It owns the ready/valid sequencing, back-pressure and flush of the decode stage.

## Interface
Parameters:
- `PC_W`, default 32: width of the PC field carried alongside the instruction.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `in_valid`  in  1  IFU presents an instruction.
- `in_ready`  out  1  this block accepts the instruction this cycle.
- `in_inst`  in  32  raw instruction word.
- `in_pc`  in  PC_W  instruction PC.
- `flush`  in  1  redirect from EXU; kill the held and incoming instruction.
- `out_valid`  out  1  decoded slot valid toward EXU.
- `out_ready`  in  1  EXU consumes the slot.
- `out_inst`  out  32  registered instruction.
- `out_pc`  out  PC_W  registered PC.
- `out_imm`  out  32  registered immediate.
- `out_immsel`  out  immsel_e  registered selector.
- `out_illegal`  out  1  opcode not recognised.

## Operation
- Opcode map on `in_inst[6:0]`:
  - 0110111 / 0010111 → IMM_U
  - 1101111 → IMM_J
  - 1100111, 0000011, 0010011, 1110011 → IMM_I
  - 0100011 → IMM_S
  - 1100011 → IMM_B
  - 0110011 → IMM_I with `out_imm` forced to 0
- Any other opcode, or `in_inst[1:0]` ≠ 2'b11, gives illegal:
  - `out_illegal`=1, `out_imm`=0, `out_immsel`=IMM_I.
- The selector feeds `ImmGen` combinationally. The result is captured only on an accepted transfer.
- Accept condition: `in_valid && in_ready && !flush`. On accept, all `out_*` fields load and `out_valid` is set to 1.
- Slot frees when `out_valid && out_ready`. If no new accept occurs in the same cycle, `out_valid` clears to 0.
- Without the skid feature: `in_ready = !out_valid || out_ready`. This is a combinational path from `out_ready`.
- Simultaneous consume and accept: the slot reloads with the new instruction and `out_valid` stays 1 (full throughput).
- `flush`=1:
  - `out_valid` goes to 0 on the next edge.
  - The incoming instruction is dropped.
  - `in_ready` is still driven per its rule, so the IFU sees the beat consumed and discarded.
  - Flush wins over a simultaneous accept.
- Reset (`rst_n`=0 at an edge): `out_valid`=0, `out_inst`=0, `out_pc`=0, `out_imm`=0, `out_immsel`=IMM_I, `out_illegal`=0.
  - Reset mid-transfer discards the slot.
  - `in_ready` reads 1 after reset.
- Data fields hold their value while `out_valid && !out_ready`. They may be left unchanged when `out_valid`=0.

## Timing
- Latency: 1 cycle from accepted input to `out_valid`.
- Throughput: 1 instruction/cycle with `out_ready` held at 1.
- `out_*` are registered outputs.
- `in_ready` is combinational from `out_ready` unless the skid feature is compiled in.
- Once `out_valid` is asserted, the `out_*` fields stay stable until consumed or flushed.

## Configuration
- `IDU_SKID_EN` defined:
  - Adds a second (skid) entry. `in_ready` becomes a register meaning "skid entry empty", so there is no comb path from `out_ready`.
  - While stalled, one extra beat is parked in the skid entry.
  - When the main slot drains, the skid entry moves to the main slot on the next edge.
  - Flush and reset clear both entries.
  - Latency to `out_valid` is still 1 cycle when the path is unstalled.
- Undefined: single slot, combinational `in_ready` as above.

## Structure
- `cpu_types_pkg` holds:
  - `immsel_e` (existing).
  - New `OPC_LUI`, `OPC_AUIPC`, `OPC_JAL`, `OPC_JALR`, `OPC_BRANCH`, `OPC_LOAD`, `OPC_STORE`, `OPC_OPIMM`, `OPC_OP`, `OPC_SYSTEM` 7-bit constants.
  - A `dec_slot_t` struct with fields inst, pc, imm, immsel, illegal.
- The only sub-module is the existing `ImmGen` instance. The decode logic and slot/skid registers stay local to this block.

## Test plan
- Reset, then `addi x1,x0,-1` (0xFFF00093), `out_ready`=1 → next cycle: `out_valid`=1, `out_imm`=0xFFFFFFFF, `out_immsel`=IMM_I, `out_illegal`=0.
- Back-to-back `lui` 0x123450B7 then `beq` 0xFE000EE3, `out_ready`=1 → consecutive cycles show imm 0x12345000 (IMM_U), then 0xFFFFFFFC (IMM_B). No bubble.
- Hold `out_ready`=0 after one accept → `in_ready`=0 and out fields stable for 5 cycles. Without `IDU_SKID_EN` a second `in_valid` is not taken; with it, exactly one extra beat is taken. Release `out_ready` → drain in order.
- Instruction 0x00000000 → `out_illegal`=1, `out_imm`=0.
- `flush`=1 while a slot is stalled and `in_valid`=1 → next cycle `out_valid`=0, and the flushed instruction never appears.
- `rst_n`=0 for one edge with a stalled valid slot → all outputs at reset values; the next accepted instruction emerges normally.
